// File: rtl/accel_job_sched.sv
// accel_job_sched: multi-run job sequencer for the conv1d accelerator with watchdog, irq and memory port mux
module accel_job_sched #(
  parameter int RUN_W   = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [RUN_W-1:0] cmd_runs,
  input  logic             irq_en,
  input  logic             irq_ack,
  input  logic             host_mem_req,
  input  logic             host_mem_we,
  input  logic [31:0]      host_addr,
  input  logic [31:0]      host_wdata,
  output logic             host_gnt,
  output logic             accel_start,
  input  logic             accel_done,
  input  logic             accel_mem_req,
  input  logic             accel_mem_we,
  input  logic [31:0]      accel_addr,
  input  logic [31:0]      accel_result,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             busy,
  output logic [RUN_W-1:0] runs_done,
  output logic             err,
  output logic             irq
);
  localparam int WD_W = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, START, RUN, ERR} state_t;
  state_t state, state_n;
  logic [RUN_W-1:0] runs, runs_inc;
  logic [WD_W-1:0] wd;
  logic ien, accept, done_run, last, expire, irq_set;
  assign accept   = cmd_valid && cmd_ready;
  assign done_run = state == RUN && accel_done;
  assign runs_inc = runs_done + RUN_W'(1);
  assign last     = done_run && runs_inc == runs;
  // a done on the expiry cycle takes priority, so expiry requires no done
  assign expire   = state == RUN && !accel_done && wd == WD_W'(TIMEOUT - 2);
  assign irq_set  = (accept && cmd_runs == '0 && irq_en) || (ien && (last || expire));
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = (state == IDLE)  ? ((accept && cmd_runs != '0) ? START : IDLE)
            : (state == START) ? RUN
            : (state == RUN)   ? (done_run ? (last ? IDLE : START) : (expire ? ERR : RUN))
            : (irq_ack ? IDLE : ERR);
  end
  always_comb begin
    cmd_ready   = state == IDLE;
    accel_start = state == START;
    busy        = state == START || state == RUN;
    err         = state == ERR;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      runs      <= '0;
      ien       <= 1'b0;
      runs_done <= '0;
      wd        <= '0;
      irq       <= 1'b0;
    end else begin
      if (accept) begin
        runs      <= cmd_runs;
        ien       <= irq_en;
        runs_done <= '0;
      end
      if (done_run) runs_done <= runs_inc;
      wd  <= (state == RUN) ? wd + WD_W'(1) : '0;
      irq <= irq_set ? 1'b1 : (irq_ack ? 1'b0 : irq);
    end
  end
  // ownership comes only from registered state; requests never steer the mux
  assign host_gnt  = !busy && host_mem_req;
  assign mem_req   = busy ? accel_mem_req : host_mem_req;
  assign mem_we    = busy ? accel_mem_we : host_mem_we;
  assign mem_addr  = busy ? accel_addr : host_addr;
  assign mem_wdata = busy ? accel_result : host_wdata;
endmodule

// File: tb/tb_accel_job_sched.sv
// tb_accel_job_sched: directed and randomized checks of accel_job_sched against a timestamp-based job model
module tb_accel_job_sched;
  localparam int RW = 8;
  localparam int TO = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, irq_en = 1'b0, irq_ack = 1'b0;
  logic [RW-1:0] cmd_runs = '0;
  logic host_mem_req = 1'b0, host_mem_we = 1'b0, host_gnt;
  logic [31:0] host_addr = '0, host_wdata = '0;
  logic accel_start, accel_done = 1'b0, accel_mem_req = 1'b0, accel_mem_we = 1'b0;
  logic [31:0] accel_addr = '0, accel_result = '0;
  logic mem_req, mem_we, busy, err, irq;
  logic [31:0] mem_addr, mem_wdata;
  logic [RW-1:0] runs_done;
  int checks = 0, errors = 0;
  bit chk_on = 1'b0;

  accel_job_sched #(.RUN_W(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_runs(cmd_runs),
    .irq_en(irq_en), .irq_ack(irq_ack), .host_mem_req(host_mem_req), .host_mem_we(host_mem_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt), .accel_start(accel_start),
    .accel_done(accel_done), .accel_mem_req(accel_mem_req), .accel_mem_we(accel_mem_we),
    .accel_addr(accel_addr), .accel_result(accel_result), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .runs_done(runs_done), .err(err), .irq(irq)
  );

  always #5 clk = ~clk;

  // model: a job is active from its first pulse until the last done or expiry;
  // m_start is the cycle index of the most recent start pulse
  int cyc = 0, m_start = 0, m_runs = 0, m_cnt = 0;
  bit m_job = 1'b0, m_err = 1'b0, m_irq = 1'b0, m_ien = 1'b0;

  task automatic model_step();
    bit set = 1'b0;
    if (rst) begin
      m_job = 1'b0; m_err = 1'b0; m_irq = 1'b0; m_cnt = 0; m_runs = 0; m_ien = 1'b0;
    end else begin
      if (!m_job && !m_err) begin
        if (cmd_valid) begin
          m_runs = int'(cmd_runs); m_ien = irq_en; m_cnt = 0;
          if (cmd_runs == '0) set = irq_en;
          else begin m_job = 1'b1; m_start = cyc + 1; end
        end
      end else if (m_err) begin
        if (irq_ack) m_err = 1'b0;
      end else if (cyc > m_start) begin
        if (accel_done) begin
          m_cnt = (m_cnt + 1) % (1 << RW);
          if (m_cnt == m_runs) begin m_job = 1'b0; set = m_ien; end
          else m_start = cyc + 1;
        end else if (cyc - m_start == TO - 1) begin
          m_job = 1'b0; m_err = 1'b1; set = m_ien;
        end
      end
      m_irq = set ? 1'b1 : (irq_ack ? 1'b0 : m_irq);
    end
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) if (chk_on) begin
    chk("cmd_ready", 32'(cmd_ready), 32'(!m_job && !m_err));
    chk("accel_start", 32'(accel_start), 32'(m_job && cyc == m_start));
    chk("busy", 32'(busy), 32'(m_job));
    chk("err", 32'(err), 32'(m_err));
    chk("irq", 32'(irq), 32'(m_irq));
    chk("runs_done", 32'(runs_done), m_cnt);
    chk("host_gnt", 32'(host_gnt), 32'(!m_job && host_mem_req));
    chk("mem_req", 32'(mem_req), 32'(m_job ? accel_mem_req : host_mem_req));
    chk("mem_we", 32'(mem_we), 32'(m_job ? accel_mem_we : host_mem_we));
    chk("mem_addr", mem_addr, m_job ? accel_addr : host_addr);
    chk("mem_wdata", mem_wdata, m_job ? accel_result : host_wdata);
  end

  // accelerator stand-in: answers each start pulse after a random latency unless dead
  int dcnt = -1, lat_lo = 10, lat_hi = 10, pulses = 0;
  bit dead = 1'b0;

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    accel_done = 1'b0;
    if (dcnt > 0) dcnt--;
    if (dcnt == 0) begin accel_done = 1'b1; dcnt = -1; end
    if (accel_start) begin
      pulses++;
      if (!dead) dcnt = $urandom_range(lat_hi, lat_lo);
    end
  endtask

  task automatic wait_ready(input int bound);
    int n = 0;
    while (!cmd_ready && n < bound) begin tick(); n++; end
    chk("wait_ready_bound", 32'(cmd_ready), 1);
  endtask

  task automatic issue(input int runs, input logic ien);
    cmd_valid = 1'b1; cmd_runs = RW'(runs); irq_en = ien;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic ack();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
  endtask

  initial begin
    int n, bad;
    tick(); tick();
    rst = 1'b0; chk_on = 1'b1;
    tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_runs_done", 32'(runs_done), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_busy", 32'(busy), 0);

    // three runs, done 10 cycles after each start
    host_mem_req = 1'b1; pulses = 0;
    issue(3, 1'b1);
    n = 0; bad = 0;
    while (!cmd_ready && n < 200) begin
      if (busy && host_gnt) bad++;
      tick(); n++;
    end
    chk("job3_pulses", pulses, 3);
    chk("job3_runs_done", 32'(runs_done), 3);
    chk("job3_irq", 32'(irq), 1);
    chk("job3_gnt_while_busy", bad, 0);

    // empty job
    ack();
    chk("ack_clears_irq", 32'(irq), 0);
    pulses = 0;
    issue(0, 1'b1);
    chk("empty_irq", 32'(irq), 1);
    chk("empty_ready", 32'(cmd_ready), 1);
    tick();
    chk("empty_no_pulse", pulses, 0);

    // watchdog expiry
    ack();
    dead = 1'b1;
    issue(2, 1'b1);
    chk("wd_start", 32'(accel_start), 1);
    n = 0;
    while (!err && n < 100) begin tick(); n++; end
    chk("wd_cycles", n, TO);
    chk("wd_irq", 32'(irq), 1);
    tick();
    chk("wd_err_sticky", 32'(err), 1);
    ack();
    chk("wd_ack_err", 32'(err), 0);
    chk("wd_ack_irq", 32'(irq), 0);
    chk("wd_ack_ready", 32'(cmd_ready), 1);
    dead = 1'b0; dcnt = -1;

    // spurious done in idle, then a command held during a busy job
    accel_done = 1'b1;
    tick();
    chk("spurious_runs_done", 32'(runs_done), 0);
    lat_lo = 5; lat_hi = 5;
    issue(2, 1'b0);
    cmd_valid = 1'b1; cmd_runs = RW'(5);
    n = 0; bad = 0;
    while (!cmd_ready && n < 200) begin
      if (cmd_ready) bad++;
      tick(); n++;
    end
    chk("held_first_runs", 32'(runs_done), 2);
    tick();
    cmd_valid = 1'b0;
    chk("held_second_start", 32'(accel_start), 1);
    wait_ready(300);
    chk("held_second_runs", 32'(runs_done), 5);

    // host write to 0x40 during a run
    host_mem_req = 1'b1; host_mem_we = 1'b1; host_addr = 32'h40; host_wdata = 32'hdead;
    accel_mem_req = 1'b1; accel_mem_we = 1'b0; accel_addr = 32'h1234; accel_result = 32'h5a5a;
    issue(1, 1'b0);
    tick();
    chk("run_host_gnt", 32'(host_gnt), 0);
    chk("run_mem_addr", mem_addr, 32'h1234);
    chk("run_mem_wdata", mem_wdata, 32'h5a5a);
    wait_ready(100);
    chk("idle_host_gnt", 32'(host_gnt), 1);
    chk("idle_mem_addr", mem_addr, 32'h40);
    chk("idle_mem_we", 32'(mem_we), 1);

    // reset in the middle of a five-run job
    lat_lo = 10; lat_hi = 10;
    issue(5, 1'b1);
    repeat (15) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_runs_done", 32'(runs_done), 0);
    pulses = 0;
    repeat (30) tick();
    chk("midrst_no_pulse", pulses, 0);

    // ack on the completion cycle loses to the set
    lat_lo = 4; lat_hi = 4;
    issue(1, 1'b1);
    n = 0;
    while (!accel_done && n < 50) begin tick(); n++; end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("set_beats_ack", 32'(irq), 1);
    chk("set_beats_ack_ready", 32'(cmd_ready), 1);

    // randomized traffic
    lat_lo = 1; lat_hi = 18;
    repeat (4000) begin
      tick();
      rst = ($urandom_range(299) == 0);
      cmd_valid = ($urandom_range(3) == 0);
      cmd_runs = RW'($urandom_range(4));
      irq_en = 1'($urandom_range(1));
      irq_ack = ($urandom_range(7) == 0);
      host_mem_req = 1'($urandom_range(1)); host_mem_we = 1'($urandom_range(1));
      host_addr = $urandom; host_wdata = $urandom;
      accel_mem_req = 1'($urandom_range(1)); accel_mem_we = 1'($urandom_range(1));
      accel_addr = $urandom; accel_result = $urandom;
      if ($urandom_range(40) == 0) accel_done = 1'b1;
    end
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
